// File: rtl/acos_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : acos_pkg
// Purpose  : Shared constants and state encoding for the inverse-cosine unit
//            (acos_deg) and its quarter-wave cosine table (cos_deg_rom).
// Contents : SCALE        fixed-point scale of cosine values (1.0 = 10000)
//            QUARTER_DEG  90, upper bound of the table / search interval
//            HALF_DEG     180, used to reflect results for negative inputs
//            TAB_W        width of one table entry (14-bit unsigned)
//            ANG_W        width of internal angle arithmetic (8-bit)
//            acos_state_t IDLE / SEARCH / FINAL
// Revision : 1.0  initial release
// ============================================================================
package acos_pkg;

  localparam int SCALE = 10000;
  localparam int TAB_W = 14;
  localparam int ANG_W = 8;

  localparam logic [ANG_W-1:0] QUARTER_DEG = 8'd90;
  localparam logic [ANG_W-1:0] HALF_DEG    = 8'd180;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FINAL  = 2'd2
  } acos_state_t;

endpackage
`default_nettype wire

// File: rtl/cos_deg_rom.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cos_deg_rom
// Purpose  : Combinational quarter-wave cosine table, 91 entries holding
//            round(cos(d) * 10000) for d = 0..90. Addresses above 90 read 0.
// Ports    : addr_a  in  8   angle for read port A (search midpoint)
//            addr_b  in  8   angle for read port B (neighbour below lo)
//            data_a  out 14  table value at addr_a
//            data_b  out 14  table value at addr_b
// Revision : 1.0  initial release
// ============================================================================
module cos_deg_rom
  import acos_pkg::*;
(
  input  logic [ANG_W-1:0] addr_a,
  input  logic [ANG_W-1:0] addr_b,
  output logic [TAB_W-1:0] data_a,
  output logic [TAB_W-1:0] data_b
);

  localparam logic [TAB_W-1:0] COS_TAB [0:90] = '{
    14'd10000, 14'd9998, 14'd9994, 14'd9986, 14'd9976, 14'd9962, 14'd9945, 14'd9925,
    14'd9903,  14'd9877, 14'd9848, 14'd9816, 14'd9781, 14'd9744, 14'd9703, 14'd9659,
    14'd9613,  14'd9563, 14'd9511, 14'd9455, 14'd9397, 14'd9336, 14'd9272, 14'd9205,
    14'd9135,  14'd9063, 14'd8988, 14'd8910, 14'd8829, 14'd8746, 14'd8660, 14'd8572,
    14'd8480,  14'd8387, 14'd8290, 14'd8192, 14'd8090, 14'd7986, 14'd7880, 14'd7771,
    14'd7660,  14'd7547, 14'd7431, 14'd7314, 14'd7193, 14'd7071, 14'd6947, 14'd6820,
    14'd6691,  14'd6561, 14'd6428, 14'd6293, 14'd6157, 14'd6018, 14'd5878, 14'd5736,
    14'd5592,  14'd5446, 14'd5299, 14'd5150, 14'd5000, 14'd4848, 14'd4695, 14'd4540,
    14'd4384,  14'd4226, 14'd4067, 14'd3907, 14'd3746, 14'd3584, 14'd3420, 14'd3256,
    14'd3090,  14'd2924, 14'd2756, 14'd2588, 14'd2419, 14'd2250, 14'd2079, 14'd1908,
    14'd1736,  14'd1564, 14'd1392, 14'd1219, 14'd1045, 14'd872,  14'd698,  14'd523,
    14'd349,   14'd175,  14'd0
  };

  function automatic logic [TAB_W-1:0] lookup(input logic [ANG_W-1:0] a);
    if (a <= QUARTER_DEG) lookup = COS_TAB[a[6:0]];
    else                  lookup = '0;
  endfunction

  assign data_a = lookup(addr_a);
  assign data_b = lookup(addr_b);

endmodule
`default_nettype wire

// File: rtl/acos_deg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : acos_deg
// Purpose  : Sequential inverse cosine. Converts a signed cosine value scaled
//            by SCALE into an integer angle 0..180 degrees using a fixed
//            ITER-step binary search over a quarter-wave cosine table.
//            Latency is 8 cycles from the accepting edge to done.
// Ports    : clk    in  1   system clock, rising edge
//            rst    in  1   synchronous active-high reset
//            start  in  1   request pulse, sampled only in IDLE
//            inp1   in  16  cosine value, two's complement, scaled by SCALE
//            busy   out 1   conversion in flight
//            done   out 1   one-cycle pulse, acos/err valid
//            acos   out 16  angle in degrees, 0..180
//            err    out 1   |inp1| exceeded SCALE (acos forced to 0)
// Config   : ACOS_ROUND_EN  defined   -> nearest-degree rounding in FINAL
//                           undefined -> result is the search bound lo
// Revision : 1.0  initial release
// ============================================================================
module acos_deg #(
  parameter int SCALE = 10000,
  parameter int ITER  = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] inp1,
  output logic        busy,
  output logic        done,
  output logic [15:0] acos,
  output logic        err
);
  import acos_pkg::*;

  localparam logic [3:0]  LAST_STEP = 4'(ITER - 1);
  localparam logic [16:0] SCALE_MAG = 17'(SCALE);

  acos_state_t      state;
  logic             sign;
  logic [16:0]      mag;
  logic [ANG_W-1:0] lo;
  logic [ANG_W-1:0] hi;
  logic [3:0]       cnt;

  logic [16:0]      inp_ext;
  logic [16:0]      inp_mag;
  logic [ANG_W-1:0] sum;
  logic [ANG_W-1:0] mid;
  logic [ANG_W-1:0] d;
  logic [TAB_W-1:0] rom_mid;

  // 17-bit magnitude so that -32768 does not overflow.
  always_comb begin
    inp_ext = {inp1[15], inp1};
    inp_mag = inp1[15] ? (17'd0 - inp_ext) : inp_ext;
    sum     = lo + hi;
    mid     = sum >> 1;
  end

`ifdef ACOS_ROUND_EN
  logic [TAB_W-1:0]  rom_prev;
  logic [ANG_W-1:0]  lo_m1;
  logic signed [16:0] diff_prev;
  logic signed [16:0] diff_cur;

  assign lo_m1 = lo - 8'd1;

  cos_deg_rom u_rom (
    .addr_a (mid),
    .addr_b (lo_m1),
    .data_a (rom_mid),
    .data_b (rom_prev)
  );

  // In FINAL the search has converged (lo == hi), so mid == lo and port A
  // already returns rom(lo); only rom(lo-1) needs the second port.
  assign diff_prev = $signed({3'b000, rom_prev}) - $signed(mag);
  assign diff_cur  = $signed(mag) - $signed({3'b000, rom_mid});
  assign d = ((lo != 8'd0) && (diff_prev < diff_cur)) ? lo_m1 : lo;
`else
  logic [TAB_W-1:0] unused_rom_b;

  cos_deg_rom u_rom (
    .addr_a (mid),
    .addr_b ({ANG_W{1'b0}}),
    .data_a (rom_mid),
    .data_b (unused_rom_b)
  );

  assign d = lo;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      acos  <= 16'd0;
      err   <= 1'b0;
      sign  <= 1'b0;
      mag   <= 17'd0;
      lo    <= '0;
      hi    <= '0;
      cnt   <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign  <= inp1[15];
            mag   <= inp_mag;
            lo    <= '0;
            hi    <= QUARTER_DEG;
            cnt   <= 4'd0;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          // Once converged the interval is frozen for the remaining steps,
          // keeping the latency fixed regardless of input.
          if (lo != hi) begin
            if ({3'b000, rom_mid} <= mag) hi <= mid;
            else                          lo <= mid + 8'd1;
          end
          cnt <= cnt + 4'd1;
          if (cnt == LAST_STEP) state <= FINAL;
        end
        FINAL: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (mag > SCALE_MAG) begin
            err  <= 1'b1;
            acos <= 16'd0;
          end else begin
            err  <= 1'b0;
            acos <= sign ? {8'd0, HALF_DEG - d} : {8'd0, d};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acos_deg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_acos_deg
// Purpose  : Self-checking bench for acos_deg. Stimulus pushes expected
//            results (with the cycle they are due) into a scoreboard queue;
//            a monitor pops and compares whenever done is seen. Expected
//            angles come from a reference built with real-valued cosine.
// Revision : 1.0  initial release
// ============================================================================
module tb_acos_deg;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] inp1;
  logic        busy;
  logic        done;
  logic [15:0] acos;
  logic        err;

  always #5 clk = ~clk;

  acos_deg #(.SCALE(10000), .ITER(7)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .inp1  (inp1),
    .busy  (busy),
    .done  (done),
    .acos  (acos),
    .err   (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] acos;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;
  int   tab [0:90];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Angle in 0..90 for a magnitude within range, from the real-valued table.
  function automatic int ref_deg(input int m);
    int best;
`ifdef ACOS_ROUND_EN
    // nearest table entry; equal distance resolves to the larger angle
    best = 0;
    for (int k = 1; k <= 90; k++)
      if (iabs(tab[k] - m) <= iabs(tab[best] - m)) best = k;
`else
    // smallest angle whose cosine does not exceed the magnitude
    best = 90;
    for (int k = 90; k >= 0; k--)
      if (tab[k] <= m) best = k;
`endif
    return best;
  endfunction

  task automatic push_exp(input logic [15:0] a, input logic e);
    exp_t x;
    x.acos = a;
    x.err  = e;
    x.due  = cyc + 9;   // accepted at the next edge, done 8 edges after that
    q.push_back(x);
  endtask

  task automatic push_model(input logic [15:0] v);
    int sv;
    int m;
    int dg;
    sv = int'($signed(v));
    m  = iabs(sv);
    if (m > 10000) push_exp(16'd0, 1'b1);
    else begin
      dg = ref_deg(m);
      push_exp(16'((sv < 0) ? 180 - dg : dg), 1'b0);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one conversion, then return in the cycle its done is visible.
  task automatic conv(input logic [15:0] v);
    start = 1'b1;
    inp1  = v;
    push_model(v);
    tick(1);
    start = 1'b0;
    inp1  = 16'($urandom);
    tick(8);
  endtask

  task automatic conv_exp(input logic [15:0] v, input logic [15:0] a, input logic e);
    start = 1'b1;
    inp1  = v;
    push_exp(a, e);
    tick(1);
    start = 1'b0;
    inp1  = 16'($urandom);
    tick(8);
  endtask

  // Monitor: compares every done against the head of the scoreboard.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: done=1 with no pending conversion at cycle %0d, expected done=0", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("acos", 32'(acos), 32'(mon_e.acos));
        chk("err", 32'(err), 32'(mon_e.err));
        chk("latency_cycle", 32'(cyc), 32'(mon_e.due));
        chk("busy_low_at_done", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    int r;
    logic [15:0] v;

    for (int k = 0; k <= 90; k++)
      tab[k] = $rtoi($floor($cos(real'(k) * 3.14159265358979 / 180.0) * 10000.0 + 0.5));

    rst = 1'b1; start = 1'b0; inp1 = 16'd0;
    tick(3);
    // reset dominates a simultaneous start
    start = 1'b1; inp1 = 16'd5000;
    tick(1);
    chk("rst_vs_start_busy", 32'(busy), 32'd0);
    start = 1'b0; rst = 1'b0;
    tick(1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_acos", 32'(acos), 32'd0);
    chk("reset_err",  32'(err),  32'd0);

    // exact table points
    conv_exp(16'd5000,        16'd60,  1'b0);
    conv_exp(16'(-5000),      16'd120, 1'b0);
    conv_exp(16'd10000,       16'd0,   1'b0);
    conv_exp(16'(-10000),     16'd180, 1'b0);
    conv_exp(16'd0,           16'd90,  1'b0);
    chk("done_visible_for_b2b", 32'(done), 32'd1);

    // rounding
`ifdef ACOS_ROUND_EN
    conv_exp(16'd7050, 16'd45, 1'b0);
`else
    conv_exp(16'd7050, 16'd46, 1'b0);
`endif
    conv_exp(16'd7000, 16'd46, 1'b0);

    // range errors, then recovery
    conv_exp(16'd10001,   16'd0, 1'b1);
    conv_exp(16'(-12000), 16'd0, 1'b1);
    conv_exp(16'h8000,    16'd0, 1'b1);
    conv_exp(16'(-5000),  16'd120, 1'b0);

    // outputs hold after done
    tick(4);
    chk("hold_acos", 32'(acos), 32'd120);
    chk("hold_err",  32'(err),  32'd0);

    // start held for 5 cycles yields a single done
    start = 1'b1; inp1 = 16'd5000;
    push_exp(16'd60, 1'b0);
    tick(5);
    start = 1'b0;
    tick(4);

    // reset in cycle 4 of a conversion: no done, outputs cleared
    start = 1'b1; inp1 = 16'd7000;
    tick(1);
    start = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_acos", 32'(acos), 32'd0);
    chk("midrst_err",  32'(err),  32'd0);
    tick(12);
    conv_exp(16'(-10000), 16'd180, 1'b0);

    // every table point, both signs, plus its neighbours
    for (int k = 0; k <= 90; k++) begin
      conv(16'(tab[k]));
      conv(16'(-tab[k]));
      if (tab[k] < 10000) conv(16'(tab[k] + 1));
    end

    // randomized conversions with occasional idle gaps
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 15) == 0) v = 16'($urandom);
      else begin
        r = int'($urandom_range(0, 20000));
        v = 16'(r - 10000);
      end
      if ($urandom_range(0, 7) == 0) tick(int'($urandom_range(1, 3)));
      conv(v);
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
